step_move_ctrl: RTL and testbench

Motion sequencer for one stepper axis. It accepts a move command (direction, step count, step period), applies the driver direction setup time, and then fires single-cycle `start` strobes into the step-pulse generator at a fixed period until the count is exhausted or the move is aborted. It sits between the NIOS II register interface and the step-pulse generator, which produces the 5 µs (500-cycle) STEP pulse from each strobe.

---
 rtl/step_move_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_step_move_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_move_ctrl.sv
// step_move_ctrl: motion sequencer for a single stepper axis.
// Accepts a move command, waits out the driver DIR setup time, then issues
// single-cycle start strobes to the step-pulse generator at a fixed period
// until the step count is exhausted or the move is aborted.
// Optional feature macro: STEP_POS_EN (signed step position counter on pos_o).
module step_move_ctrl #(
    parameter int COUNT_W    = 16,
    parameter int PERIOD_W   = 24,
    parameter int DIR_SETUP  = 200,
    parameter int MIN_PERIOD = 600
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                step_start,
    output logic                mt_dir_o,
    output logic                mt_en_o,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [31:0]         pos_o,
    input  logic                pos_clr
);

    // Setup counter holds DIR_SETUP-1 down to 0.
    localparam int SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic [PERIOD_W-1:0] MIN_P       = PERIOD_W'(MIN_PERIOD);
    localparam logic [SETUP_W-1:0]  SETUP_LOAD  = SETUP_W'(DIR_SETUP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_STEP  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Effective period: never shorter than the pulse width plus low time.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W-1:0] r;
        if (p < MIN_P) begin
            r = MIN_P;
        end else begin
            r = p;
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [SETUP_W-1:0]   setup_cnt_r;
    logic [PERIOD_W-1:0]  per_cnt_r;
    logic [PERIOD_W-1:0]  period_r;
    logic [COUNT_W-1:0]   rem_r;
    logic                 dir_r;

    logic                 accept_s;
    logic                 abort_s;

    logic                 ready_s;
    logic                 start_s;
    logic                 busy_s;
    logic                 done_s;
    logic                 aborted_s;

    logic                 ready_r;
    logic                 start_r;
    logic                 en_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 aborted_r;

    assign accept_s = cmd_valid && (state_r == S_IDLE);
    // Abort only matters while a move is actually in flight.
    assign abort_s  = abort && ((state_r == S_SETUP) || (state_r == S_STEP) ||
                                (state_r == S_WAIT));

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort outranks every in-move transition, including into STEP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (cmd_steps == '0) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_SETUP;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SETUP: begin
                if (abort_s) begin
                    state_s = S_DONE;
                end else if (setup_cnt_r == '0) begin
                    state_s = S_STEP;
                end else begin
                    state_s = S_SETUP;
                end
            end
            S_STEP: begin
                if (abort_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_s) begin
                    state_s = S_DONE;
                end else if (per_cnt_r == '0) begin
                    if (rem_r != '0) begin
                        state_s = S_STEP;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the output flops align with the state flop.
    always_comb begin
        ready_s   = (state_s == S_IDLE);
        start_s   = (state_s == S_STEP);
        busy_s    = (state_s != S_IDLE);
        done_s    = (state_s == S_DONE);
        aborted_s = (state_s == S_DONE) && abort_s;
    end

    // Registered control outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r   <= 1'b1;
            start_r   <= 1'b0;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            ready_r   <= ready_s;
            start_r   <= start_s;
            en_r      <= busy_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    // Command latch, direction register and the setup/period/remaining counters.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_cnt_r <= '0;
            per_cnt_r   <= '0;
            period_r    <= '0;
            rem_r       <= '0;
            dir_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        rem_r       <= cmd_steps;
                        period_r    <= clamp_period(cmd_period);
                        setup_cnt_r <= SETUP_LOAD;
                        // A zero-step command leaves the driver DIR pin alone.
                        if (cmd_steps != '0) begin
                            dir_r <= cmd_dir;
                        end else begin
                            dir_r <= dir_r;
                        end
                    end else begin
                        rem_r <= rem_r;
                    end
                end
                S_SETUP: begin
                    if (setup_cnt_r != '0) begin
                        setup_cnt_r <= setup_cnt_r - SETUP_W'(1);
                    end else begin
                        setup_cnt_r <= setup_cnt_r;
                    end
                end
                S_STEP: begin
                    if (rem_r != '0) begin
                        rem_r <= rem_r - COUNT_W'(1);
                    end else begin
                        rem_r <= rem_r;
                    end
                    // WAIT spans P-1 cycles after the strobe; counter ends at zero.
                    per_cnt_r <= period_r - PERIOD_W'(2);
                end
                S_WAIT: begin
                    if (per_cnt_r != '0) begin
                        per_cnt_r <= per_cnt_r - PERIOD_W'(1);
                    end else begin
                        per_cnt_r <= per_cnt_r;
                    end
                end
                S_DONE: begin
                    rem_r <= rem_r;
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_r;
    assign step_start = start_r;
    assign mt_dir_o   = dir_r;
    assign mt_en_o    = en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign aborted    = aborted_r;

`ifdef STEP_POS_EN
    logic [31:0] pos_r;

    // Signed position counter; a clear in the same cycle as a strobe wins.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= 32'd0;
        end else if (pos_clr) begin
            pos_r <= 32'd0;
        end else if (start_r) begin
            if (dir_r) begin
                pos_r <= pos_r + 32'd1;
            end else begin
                pos_r <= pos_r - 32'd1;
            end
        end else begin
            pos_r <= pos_r;
        end
    end

    assign pos_o = pos_r;
`else
    logic unused_pos_clr_s;
    assign unused_pos_clr_s = pos_clr;
    assign pos_o            = 32'd0;
`endif

endmodule

// File: tb/tb_step_move_ctrl.sv
// Directed testbench for step_move_ctrl with hand-computed cycle offsets.
module tb_step_move_ctrl;

    logic        sys_clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        abort;
    logic        step_start;
    logic        mt_dir_o;
    logic        mt_en_o;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] pos_o;
    logic        pos_clr;

    int vecs;
    int errs;

    int t;
    int st [0:15];
    int nst;
    int done_t;
    int ready_t;
    int dir_t;
    int early_ready;
    logic ab_seen;
    logic dir_before;

    step_move_ctrl dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_start (step_start),
        .mt_dir_o   (mt_dir_o),
        .mt_en_o    (mt_en_o),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pos_o      (pos_o),
        .pos_clr    (pos_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge; it is accepted at the following posedge (edge A).
    task automatic issue(input logic d, input int steps, input int period, input bit hold);
        @(negedge sys_clk);
        cmd_dir    = d;
        cmd_steps  = steps[15:0];
        cmd_period = period[23:0];
        cmd_valid  = 1'b1;
        dir_before = mt_dir_o;
        @(posedge sys_clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Observe cycles A+1, A+2, ...; t is the offset from the accept edge.
    task automatic run_move(input int max_t, input int abort_t, input bit drop_on_done);
        t = 0; nst = 0; done_t = -1; ready_t = -1; dir_t = -1; early_ready = 0;
        ab_seen = 1'b0;
        for (int i = 0; i < 16; i++) st[i] = -1;
        while (t < max_t && ready_t < 0) begin
            @(negedge sys_clk);
            t++;
            if (step_start && nst < 16) begin
                st[nst] = t;
                nst++;
            end
            if (mt_dir_o !== dir_before && dir_t < 0) dir_t = t;
            if (done && done_t < 0) begin
                done_t  = t;
                ab_seen = aborted;
                if (drop_on_done) cmd_valid = 1'b0;
            end else if (done_t >= 0 && cmd_ready && ready_t < 0) begin
                ready_t = t;
            end
            if (done_t < 0 && cmd_ready) early_ready++;
            if (t == abort_t) abort = 1'b1;
            else abort = 1'b0;
        end
        abort = 1'b0;
    endtask

    initial begin
        vecs = 0; errs = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd0;
        cmd_period = 24'd0; abort = 1'b0; pos_clr = 1'b0;
        #23;
        // Reset state
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_start", {31'd0, step_start}, 32'd0);
        chk("rst_en", {31'd0, mt_en_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dir", {31'd0, mt_dir_o}, 32'd0);
        chk("rst_pos", pos_o, 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Abort is ignored while idle
        abort = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("idle_abort_done", {31'd0, done}, 32'd0);
        chk("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);
        abort = 1'b0;

        // Basic move: 3 steps, period 1000, forward
        issue(1'b1, 3, 1000, 1'b0);
        run_move(5000, -1, 1'b0);
        chk("basic_nst", nst, 32'd3);
        chk("basic_s0", st[0], 32'd201);
        chk("basic_s1", st[1], 32'd1201);
        chk("basic_s2", st[2], 32'd2201);
        chk("basic_done", done_t, 32'd3201);
        chk("basic_aborted", {31'd0, ab_seen}, 32'd0);
        chk("basic_ready", ready_t, 32'd3202);
        chk("basic_early_ready", early_ready, 32'd0);
        chk("basic_dir", {31'd0, mt_dir_o}, 32'd1);
`ifdef STEP_POS_EN
        chk("basic_pos", pos_o, 32'd3);
`else
        chk("basic_pos", pos_o, 32'd0);
`endif

        // Period clamp: 100 requested, 600 used
        issue(1'b1, 2, 100, 1'b0);
        run_move(5000, -1, 1'b0);
        chk("clamp_nst", nst, 32'd2);
        chk("clamp_s0", st[0], 32'd201);
        chk("clamp_s1", st[1], 32'd801);
        chk("clamp_done", done_t, 32'd1401);
`ifdef STEP_POS_EN
        chk("clamp_pos", pos_o, 32'd5);
`else
        chk("clamp_pos", pos_o, 32'd0);
`endif

        // Abort sampled at edge A+1500 (mid-WAIT after the second strobe)
        issue(1'b1, 5, 1000, 1'b0);
        run_move(8000, 1500, 1'b0);
        chk("abort_nst", nst, 32'd2);
        chk("abort_s1", st[1], 32'd1201);
        chk("abort_done", done_t, 32'd1501);
        chk("abort_aborted", {31'd0, ab_seen}, 32'd1);
        chk("abort_ready", ready_t, 32'd1502);
`ifdef STEP_POS_EN
        chk("abort_pos", pos_o, 32'd7);
`else
        chk("abort_pos", pos_o, 32'd0);
`endif

        // Reverse move with cmd_valid held high (and a different count) while busy
        issue(1'b0, 2, 700, 1'b1);
        cmd_steps = 16'd7;
        cmd_dir   = 1'b1;
        run_move(5000, -1, 1'b1);
        chk("busy_nst", nst, 32'd2);
        chk("busy_dir_t", dir_t, 32'd1);
        chk("busy_s0", st[0], 32'd201);
        chk("busy_s1", st[1], 32'd901);
        chk("busy_done", done_t, 32'd1601);
        chk("busy_early_ready", early_ready, 32'd0);
        chk("busy_dir_final", {31'd0, mt_dir_o}, 32'd0);
`ifdef STEP_POS_EN
        chk("busy_pos", pos_o, 32'd5);
`else
        chk("busy_pos", pos_o, 32'd0);
`endif

        // Zero steps: immediate done, DIR unchanged (stays 0 despite cmd_dir=1)
        issue(1'b1, 0, 1000, 1'b0);
        run_move(100, -1, 1'b0);
        chk("zero_nst", nst, 32'd0);
        chk("zero_done", done_t, 32'd1);
        chk("zero_ready", ready_t, 32'd2);
        chk("zero_aborted", {31'd0, ab_seen}, 32'd0);
        chk("zero_dir_t", dir_t, 32'hFFFF_FFFF);

        // Position clear
        @(negedge sys_clk);
        pos_clr = 1'b1;
        @(negedge sys_clk);
        pos_clr = 1'b0;
        chk("pos_clr", pos_o, 32'd0);

        // Reset in the middle of WAIT
        issue(1'b1, 3, 1000, 1'b0);
        run_move(500, -1, 1'b0);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        chk("midrst_nst_before", nst, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_en", {31'd0, mt_en_o}, 32'd0);
        chk("midrst_dir", {31'd0, mt_dir_o}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_pos", pos_o, 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("postrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("postrst_start", {31'd0, step_start}, 32'd0);

        // FSM is idle after reset: a zero-step command completes normally
        issue(1'b1, 0, 600, 1'b0);
        run_move(100, -1, 1'b0);
        chk("postrst_zero_done", done_t, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
